weight_fetch_ctrl: RTL

- Upstream feeder for the 4-lane weights register file (68-bit, 4 x 17-bit).
- Reads 17-bit weights one per cycle from a weight BRAM and packs 4 consecutive weights into one 68-bit group.
- Drives the group plus a 1-cycle load strobe; the strobe connects directly to the register file's enable.
- Walks num_groups groups from a base address; the consumer requests each group after the first with grp_req.

---
 rtl/wfetch_pkg.sv | 21 ++
 rtl/wfetch_rd_pipe.sv | 30 +++
 rtl/weight_fetch_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wfetch_pkg.sv
// Shared types and constants for the weight fetch controller.
// The top-level optional loop feature is enabled with the WFETCH_LOOP_EN macro.
package wfetch_pkg;

  localparam int WTS_W_DEF = 17;
  localparam int LANES_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_WAIT_REQ,
    S_FIN
  } state_t;

  function automatic int packed_w(input int wts_w, input int lanes);
    return wts_w * lanes;
  endfunction

endpackage

// File: rtl/wfetch_rd_pipe.sv
// Delay line that tracks BRAM read enables so returning data can be captured
// exactly DEPTH cycles after the read was issued.
module wfetch_rd_pipe
  import wfetch_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_vld,
  output logic o_vld
);

  logic [DEPTH-1:0] r_sr;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_vld = r_sr[DEPTH-1];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Reads LANES weights per group from BRAM, packs them and presents each group with a load strobe.
// Define WFETCH_LOOP_EN to add the `loop` input that re-walks the group list until reset.
module weight_fetch_ctrl
  import wfetch_pkg::*;
#(
  parameter int WTS_W  = WTS_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ADDR_W = 12,
  parameter int GRP_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [GRP_W-1:0]                   num_groups,
  input  logic                               grp_req,
`ifdef WFETCH_LOOP_EN
  input  logic                               loop,
`endif
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [WTS_W-1:0]                   mem_rd_data,
  output logic [packed_w(WTS_W, LANES)-1:0]  wts_out,
  output logic                               wts_load,
  output logic                               busy,
  output logic                               done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]             r_base;
  logic [ADDR_W-1:0]             r_addr;
  logic [GRP_W-1:0]              r_num;
  logic [GRP_W-1:0]              r_grp;
  logic [LANE_W-1:0]             r_lane;
  logic [LANE_W-1:0]             r_cap_idx;
  logic [LANES-1:0][WTS_W-1:0]   r_shadow;
  logic [LANES-1:0][WTS_W-1:0]   r_wts;
  logic [LANES-1:0][WTS_W-1:0]   w_merged;
  logic                          w_vld;
  logic                          w_cap_last;
  logic                          w_last_grp;
  logic                          w_loop;

`ifdef WFETCH_LOOP_EN
  logic r_loop;
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  wfetch_rd_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
    .clock (clock),
    .reset (reset),
    .i_vld (mem_rd_en),
    .o_vld (w_vld)
  );

  assign w_cap_last = w_vld && (r_cap_idx == LAST_LANE);
  assign w_last_grp = (r_grp == r_num - GRP_W'(1));
  assign mem_addr   = mem_rd_en ? r_addr : '0;
  assign wts_out    = r_wts;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_merged            = r_shadow;
    w_merged[r_cap_idx] = mem_rd_data;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    wts_load  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (num_groups == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        if (r_lane == LAST_LANE) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cap_last) w_next = S_PRESENT;
      end
      S_PRESENT: begin
        wts_load = 1'b1;
        if (w_last_grp) begin
          done   = w_loop;
          w_next = w_loop ? S_WAIT_REQ : S_FIN;
        end else begin
          w_next = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: begin
        if (grp_req) w_next = S_FETCH;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the shadow and output pack registers are cleared on reset so an aborted run leaves no stale group.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base    <= '0;
      r_addr    <= '0;
      r_num     <= '0;
      r_grp     <= '0;
      r_lane    <= '0;
      r_cap_idx <= '0;
      r_shadow  <= '0;
      r_wts     <= '0;
`ifdef WFETCH_LOOP_EN
      r_loop    <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_base <= base_addr;
        r_addr <= base_addr;
        r_num  <= num_groups;
        r_grp  <= '0;
`ifdef WFETCH_LOOP_EN
        r_loop <= loop;
`endif
      end
      if (mem_rd_en) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + LANE_W'(1);
      end
      if (w_vld) begin
        r_shadow  <= w_merged;
        r_cap_idx <= w_cap_last ? '0 : r_cap_idx + LANE_W'(1);
      end
      if (w_cap_last) r_wts <= w_merged;
      // After the final group the counters rewind so a looping run restarts at group 0.
      if (wts_load) begin
        if (w_last_grp) begin
          r_grp  <= '0;
          r_addr <= r_base;
        end else begin
          r_grp  <= r_grp + GRP_W'(1);
        end
      end
    end
  end

endmodule
